game_controller: RTL and testbench

Game-flow and scoring engine for the guitar game. It sequences the game through idle, count-in, play and game-over. It scores strike-line note events against the player's fret buttons. It feeds the seven-segment/timer block with the 2-bit game state and the 16-bit score, and consumes that block's time-up flag. It also generates the one-second tick and the timer-restart pulse that the timer block runs from.

---
 rtl/game_controller_if.sv | 25 ++
 rtl/game_controller.sv | 133 +++++++++++++
 tb/tb_game_controller.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_controller_if.sv
// Signal bundle between the game controller and the rest of the guitar game.
// master drives the player/note/timer inputs; slave is the controller itself.
interface game_controller_if;
  logic        btn_start;
  logic [4:0]  fret_hit;
  logic [4:0]  note_present;
  logic        note_valid;
  logic        time_up;
  logic [1:0]  gamestate;
  logic [15:0] display_number;
  logic [7:0]  combo;
  logic [2:0]  multiplier;
  logic        sec_tick;
  logic        timer_restart;

  modport master (
    output btn_start, fret_hit, note_present, note_valid, time_up,
    input  gamestate, display_number, combo, multiplier, sec_tick, timer_restart
  );

  modport slave (
    input  btn_start, fret_hit, note_present, note_valid, time_up,
    output gamestate, display_number, combo, multiplier, sec_tick, timer_restart
  );
endinterface

// File: rtl/game_controller.sv
// Game-flow FSM and scoring engine: idle / count-in / play / game-over,
// strike-line hit scoring with combo multiplier, and the one-second tick source.
module game_controller #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int READY_SECS = 3,
  parameter int SCORE_MAX  = 9999
) (
  input logic              clk,
  input logic              reset,
  game_controller_if.slave bus
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int READY_W = (READY_SECS > 1) ? $clog2(READY_SECS) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [READY_W-1:0] READY_LAST  = READY_W'(READY_SECS - 1);
  localparam logic [16:0]        SCORE_MAX17 = 17'(SCORE_MAX);
  localparam logic [15:0]        SCORE_MAX16 = 16'(SCORE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READY = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t              r_state;
  logic [15:0]         r_score;
  logic [7:0]          r_combo;
  logic [READY_W-1:0]  r_readyCnt;
  logic [TICK_W-1:0]   r_tickCnt;
  logic                r_secTick;
  logic                r_timerRestart;
  logic                r_btnPrev;

  logic                w_startEdge;
  logic                w_noteEq;
  logic                w_hit;
  logic                w_miss;
  logic [2:0]          w_mult;
  logic [16:0]         w_sum;
  logic [15:0]         w_scoreNext;

  // r_btnPrev resets high so a press held across reset release is not an edge.
  assign w_startEdge = bus.btn_start & ~r_btnPrev;
  assign w_noteEq    = (bus.fret_hit == bus.note_present);
  assign w_hit       = bus.note_valid && (bus.note_present != 5'd0) && w_noteEq;
  assign w_miss      = bus.note_valid && (bus.note_present != 5'd0) && !w_noteEq;

  always_comb begin
    w_mult = 3'd1;
    if (r_combo >= 8'd30)
      w_mult = 3'd4;
    else if (r_combo >= 8'd20)
      w_mult = 3'd3;
    else if (r_combo >= 8'd10)
      w_mult = 3'd2;
  end

  // Saturate before the register write so the display never shows more than SCORE_MAX.
  assign w_sum       = {1'b0, r_score} + {14'd0, w_mult};
  assign w_scoreNext = (w_sum > SCORE_MAX17) ? SCORE_MAX16 : w_sum[15:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tickCnt <= '0;
      r_secTick <= 1'b0;
    end else if (r_tickCnt == TICK_LAST) begin
      r_tickCnt <= '0;
      r_secTick <= 1'b1;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
      r_secTick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_score        <= '0;
      r_combo        <= '0;
      r_readyCnt     <= '0;
      r_timerRestart <= 1'b0;
      r_btnPrev      <= 1'b1;
    end else begin
      r_btnPrev      <= bus.btn_start;
      r_timerRestart <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_startEdge) begin
            r_state        <= READY;
            r_score        <= '0;
            r_combo        <= '0;
            r_readyCnt     <= '0;
            r_timerRestart <= 1'b1;
          end
        end
        READY: begin
          if (r_secTick) begin
            if (r_readyCnt == READY_LAST)
              r_state <= PLAY;
            else
              r_readyCnt <= r_readyCnt + 1'b1;
          end
        end
        PLAY: begin
          if (w_hit) begin
            r_score <= w_scoreNext;
            if (r_combo != 8'hFF)
              r_combo <= r_combo + 8'd1;
          end else if (w_miss) begin
            r_combo <= '0;
          end
          if (bus.time_up)
            r_state <= OVER;
        end
        OVER: begin
          if (w_startEdge)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gamestate      = r_state;
  assign bus.display_number = r_score;
  assign bus.combo          = r_combo;
  assign bus.multiplier     = w_mult;
  assign bus.sec_tick       = r_secTick;
  assign bus.timer_restart  = r_timerRestart;

endmodule

// File: tb/tb_game_controller.sv
// Randomized and directed bench for game_controller, checked every cycle
// against an integer-level model of the game rules.
module tb_game_controller;

  localparam int TICK_DIV   = 10;
  localparam int READY_SECS = 3;
  localparam int SCORE_MAX  = 9999;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  game_controller_if bus();

  game_controller #(
    .TICK_DIV   (TICK_DIV),
    .READY_SECS (READY_SECS),
    .SCORE_MAX  (SCORE_MAX)
  ) dut (
    .clk   (clk),
    .reset (rstN),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  typedef struct {
    int st;
    int score;
    int combo;
    int readyTicks;
    int edges;
    bit btnPrev;
    bit tick;
    bit restart;
  } model_t;

  model_t m;

  function automatic int multOf(input int c);
    int r;
    r = 1 + c / 10;
    return (r > 4) ? 4 : r;
  endfunction

  function automatic model_t resetModel();
    model_t r;
    r.st = 0; r.score = 0; r.combo = 0; r.readyTicks = 0; r.edges = 0;
    r.btnPrev = 1'b1; r.tick = 1'b0; r.restart = 1'b0;
    return r;
  endfunction

  // One clock of game rules: state 0 idle, 1 count-in, 2 play, 3 over.
  function automatic model_t stepModel(input model_t cur, input logic btn, input logic [4:0] fret,
                                       input logic [4:0] pres, input logic valid, input logic tup);
    model_t n;
    bit startEdge;
    int sum;
    n = cur;
    startEdge = btn && !cur.btnPrev;
    n.btnPrev = btn;
    n.restart = 1'b0;
    case (cur.st)
      0: if (startEdge) begin
           n.st = 1; n.score = 0; n.combo = 0; n.readyTicks = 0; n.restart = 1'b1;
         end
      1: if (cur.tick) begin
           n.readyTicks = cur.readyTicks + 1;
           if (n.readyTicks == READY_SECS) n.st = 2;
         end
      2: begin
           if (valid && pres != 5'd0) begin
             if (fret == pres) begin
               sum = cur.score + multOf(cur.combo);
               n.score = (sum > SCORE_MAX) ? SCORE_MAX : sum;
               n.combo = (cur.combo >= 255) ? 255 : cur.combo + 1;
             end else begin
               n.combo = 0;
             end
           end
           if (tup) n.st = 3;
         end
      default: if (startEdge) n.st = 0;
    endcase
    n.edges = cur.edges + 1;
    n.tick  = (n.edges % TICK_DIV) == 0;
    return n;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN)
      m <= resetModel();
    else
      m <= stepModel(m, bus.btn_start, bus.fret_hit, bus.note_present, bus.note_valid, bus.time_up);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cyc_gamestate", bus.gamestate, m.st);
      checkOutput("cyc_display", bus.display_number, m.score);
      checkOutput("cyc_combo", bus.combo, m.combo);
      checkOutput("cyc_multiplier", bus.multiplier, multOf(m.combo));
      checkOutput("cyc_sec_tick", bus.sec_tick, m.tick);
      checkOutput("cyc_timer_restart", bus.timer_restart, m.restart);
    end
  end

  // Drives one cycle of inputs and returns 2 time units after the sampling edge.
  task automatic applyStimulus(input logic btn, input logic [4:0] fret, input logic [4:0] pres,
                               input logic valid, input logic tup);
    bus.btn_start    = btn;
    bus.fret_hit     = fret;
    bus.note_present = pres;
    bus.note_valid   = valid;
    bus.time_up      = tup;
    @(posedge clk);
    #2;
  endtask

  task automatic doHit(input logic tup);
    logic [4:0] p;
    p = 5'($urandom_range(1, 31));
    applyStimulus(1'b0, p, p, 1'b1, tup);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gamestate"}, bus.gamestate, 0);
    checkOutput({tag, "_display"}, bus.display_number, 0);
    checkOutput({tag, "_combo"}, bus.combo, 0);
    checkOutput({tag, "_multiplier"}, bus.multiplier, 1);
    checkOutput({tag, "_sec_tick"}, bus.sec_tick, 0);
    checkOutput({tag, "_timer_restart"}, bus.timer_restart, 0);
  endtask

  task automatic enterPlay();
    int readyLen;
    int guard;
    logic [4:0] p;
    logic v;
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("enter_gamestate", bus.gamestate, 1);
    checkOutput("enter_restart", bus.timer_restart, 1);
    readyLen = 1;
    guard = 0;
    do begin
      p = 5'($urandom_range(1, 31));
      v = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, p, p, v, 1'b0);
      if (guard == 0) checkOutput("restart_one_cycle", bus.timer_restart, 0);
      guard++;
      if (bus.gamestate == 2'd1) readyLen++;
    end while (bus.gamestate == 2'd1 && guard < 100);
    checkOutput("ready_to_play", bus.gamestate, 2);
    checkOutput("ready_len_in_range",
                (readyLen >= (READY_SECS - 1) * TICK_DIV + 1) && (readyLen <= READY_SECS * TICK_DIV), 1);
    checkOutput("play_score_zero", bus.display_number, 0);
  endtask

  initial begin
    int guard;
    logic b, v, t;
    logic [4:0] p, f;
    bus.btn_start = 1'b1;
    bus.fret_hit = 5'd0;
    bus.note_present = 5'd0;
    bus.note_valid = 1'b0;
    bus.time_up = 1'b0;
    #1 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    cmpEn = 1'b1;
    checkResetValues("reset");
    rstN = 1'b1;
    repeat (4) applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("held_start_ignored", bus.gamestate, 0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Game 1: miss handling, empty strobe, simultaneous time_up, OVER hold.
    enterPlay();
    repeat (12) doHit(1'b0);
    checkOutput("hit12_score", bus.display_number, 14);
    checkOutput("hit12_combo", bus.combo, 12);
    checkOutput("hit12_mult", bus.multiplier, 2);
    checkOutput("model_hit12_score", m.score, 14);
    applyStimulus(1'b0, 5'b00011, 5'b00001, 1'b1, 1'b0);
    checkOutput("miss_combo", bus.combo, 0);
    checkOutput("miss_score", bus.display_number, 14);
    checkOutput("miss_mult", bus.multiplier, 1);
    applyStimulus(1'b0, 5'b10101, 5'd0, 1'b1, 1'b0);
    checkOutput("empty_strobe_score", bus.display_number, 14);
    checkOutput("empty_strobe_combo", bus.combo, 0);
    repeat (3) doHit(1'b0);
    doHit(1'b1);
    checkOutput("simul_score", bus.display_number, 18);
    checkOutput("simul_combo", bus.combo, 4);
    checkOutput("simul_gamestate", bus.gamestate, 3);
    repeat (3) doHit(1'b0);
    checkOutput("over_score_held", bus.display_number, 18);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("over_to_idle", bus.gamestate, 0);
    checkOutput("idle_keeps_score", bus.display_number, 18);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Game 2: multiplier ramp.
    enterPlay();
    repeat (35) doHit(1'b0);
    checkOutput("ramp_score", bus.display_number, 80);
    checkOutput("ramp_combo", bus.combo, 35);
    checkOutput("ramp_mult", bus.multiplier, 4);
    checkOutput("model_ramp_score", m.score, 80);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    checkOutput("timeup_over", bus.gamestate, 3);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Random phase: all inputs random, model-checked every cycle.
    repeat (800) begin
      b = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 1) == 0);
      t = ($urandom_range(0, 15) == 0);
      p = 5'($urandom_range(0, 31));
      f = ($urandom_range(0, 1) == 0) ? p : 5'($urandom_range(0, 31));
      applyStimulus(b, f, p, v, t);
    end

    rstN = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    rstN = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("post_random_idle", bus.gamestate, 0);

    // Game 3: asynchronous reset in the middle of play.
    enterPlay();
    repeat (29) doHit(1'b0);
    checkOutput("pre_reset_score", bus.display_number, 57);
    rstN = 1'b0;
    #1;
    checkResetValues("async_reset");
    repeat (2) applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    rstN = 1'b1;
    repeat (5) applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("after_reset_idle", bus.gamestate, 0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Game 4: score and combo saturation.
    enterPlay();
    doHit(1'b0);
    applyStimulus(1'b0, 5'b00011, 5'b00001, 1'b1, 1'b0);
    guard = 0;
    while (m.score < 9997 && guard < 4000) begin
      doHit(1'b0);
      guard++;
    end
    checkOutput("near_max_score", bus.display_number, 9997);
    checkOutput("near_max_mult", bus.multiplier, 4);
    doHit(1'b0);
    checkOutput("sat_score", bus.display_number, 9999);
    checkOutput("model_sat_score", m.score, 9999);
    repeat (5) doHit(1'b0);
    checkOutput("sat_score_hold", bus.display_number, 9999);
    checkOutput("sat_combo", bus.combo, 255);

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
